seq_mul_div: RTL and testbench
==============================

Name: seq_mul_div

Overview:
- Multi-cycle signed multiply/divide unit in the datapath ALU slice.
- Produces the 64-bit Z result pair that the bus multiplexer selects as Z_high (sel 18) and Z_low (sel 19).
- Handles MUL, DIV and REM-style results so the single-cycle ALU path stays short.
- Control unit launches an operation with start, waits for done, then gates Z_high/Z_low onto the bus.

Parameters:
- WIDTH, 32, operand width; Z_high and Z_low are each WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  reset, asynchronous, active-low.
- start  input  1  launch request, sampled on rising clk.
- op  input  1  0 = signed multiply, 1 = signed divide.
- A  input  WIDTH  multiplicand / dividend.
- B  input  WIDTH  multiplier / divisor.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when Z_high/Z_low are updated.
- div_by_zero  output  1  valid with done; high when a divide had B == 0.
- Z_high  output  WIDTH  product[2W-1:W] or remainder.
- Z_low  output  WIDTH  product[W-1:0] or quotient.

Behaviour:
- Reset (clr low, async): state IDLE, busy = 0, done = 0, div_by_zero = 0, Z_high = 0, Z_low = 0, iteration counter = 0.
- States:
  - IDLE: busy = 0, done = 0.
  - RUN: busy = 1, done = 0.
  - FIN: busy = 0, done = 1, lasts exactly one cycle.
- Transitions:
  - IDLE or FIN with start = 1 -> RUN. A, B and op are latched on that edge (the capture edge, edge 0).
  - FIN with start = 0 -> IDLE.
  - RUN -> FIN after the final iteration.
- start while busy = 1 is ignored; latched operands are unaffected. A, B and op may change freely after the capture edge.
- Multiply:
  - Radix-2 Booth, one iteration per cycle, WIDTH iterations.
  - Z written and FIN entered on edge WIDTH after capture.
  - Full signed 2W-bit product; no overflow is possible.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle, WIDTH iterations.
  - Sign correction is combinational at the write; same latency as multiply.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend. Invariant: A = Q*B + R.
  - Z_low = quotient, Z_high = remainder.
- B == 0 on divide:
  - No iterations; FIN entered on edge 1.
  - Z_low = all ones, Z_high = A, div_by_zero = 1.
- Most-negative dividend / -1: Z_low = 0x80000000 (wraps), Z_high = 0, div_by_zero = 0.
- div_by_zero is cleared on every capture edge and is 0 for all multiplies.
- Z_high/Z_low change only on the FIN-entry edge or on reset. They hold their value through IDLE and through a subsequent RUN, so the bus may read them at any time after done.
- Reset mid-operation aborts immediately to reset values; no partial result is ever written.
- Back-to-back: start held high in FIN begins the next operation. done is then a single pulse per operation.

Test Plan:
- Multiply: op = 0, A = 7, B = 0xFFFFFFFD (-3), start one cycle -> busy for 32 cycles; done one cycle after edge 32; Z_high = 0xFFFFFFFF, Z_low = 0xFFFFFFEB (-21).
- Multiply extremes: A = B = 0x7FFFFFFF -> Z_high = 0x3FFFFFFF, Z_low = 0x00000001. Then A = B = 0x80000000 -> Z_high = 0x40000000, Z_low = 0x00000000.
- Divide: op = 1, A = 0xFFFFFFEF (-17), B = 5 -> Z_low = 0xFFFFFFFD (-3), Z_high = 0xFFFFFFFE (-2), div_by_zero = 0. Also A = 100, B = 7 -> Z_low = 14, Z_high = 2.
- Divide by zero: A = 0x1234, B = 0 -> done after edge 1, div_by_zero = 1, Z_low = 0xFFFFFFFF, Z_high = 0x1234. Also A = 0x80000000, B = 0xFFFFFFFF -> Z_low = 0x80000000, Z_high = 0.
- Protocol:
  - start pulsed at cycle 10 of a running multiply with different operands -> ignored; the original result is delivered.
  - start held high through FIN -> second operation begins with no IDLE cycle.
  - Z is stable between the two done pulses.
- Reset: clr driven low at iteration 15 of a divide, asynchronous to clk -> all outputs 0 immediately. After release, a new multiply 3*4 -> Z_low = 12, Z_high = 0.

Source files
------------

// File: rtl/seq_mul_div.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes)
// unit producing the Z_high/Z_low result pair for the datapath bus.
//
// state | meaning
// IDLE  | waiting for start, results held
// RUN   | one Booth / quotient iteration per cycle, down-counter active
// FIN   | results written on entry, done pulse for one cycle
module seq_mul_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] Z_high,
   output logic [WIDTH-1:0] Z_low
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic             op_q, dz_q, a_neg, b_neg, qm1;
   logic [WIDTH:0]   hi, hi_nx, sum, shifted, trial;
   logic [WIDTH-1:0] lo, lo_nx, m, res_hi, res_lo;
   logic             capture, last;

   assign capture = start && (state != RUN);
   assign last    = (state == RUN) && (cnt == CW'(1));
   assign busy    = (state == RUN);
   assign done    = (state == FIN);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last) state_nx = FIN;
         FIN:     state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // hi is one bit wider than WIDTH so Booth never overflows on the most
   // negative multiplicand and the restoring trial keeps a valid sign bit.
   always_comb begin
      sum     = hi;
      shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
      trial   = shifted - {1'b0, m};
      hi_nx   = hi;
      lo_nx   = lo;
      if (!op_q) begin
         case ({lo[0], qm1})
            2'b01:   sum = hi + {m[WIDTH-1], m};
            2'b10:   sum = hi - {m[WIDTH-1], m};
            default: sum = hi;
         endcase
         hi_nx = {sum[WIDTH], sum[WIDTH:1]};
         lo_nx = {sum[0], lo[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
         hi_nx = trial;
         lo_nx = {lo[WIDTH-2:0], 1'b1};
      end else begin
         hi_nx = shifted;
         lo_nx = {lo[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      res_hi = hi_nx[WIDTH-1:0];
      res_lo = lo_nx;
      if (dz_q) begin
         res_hi = lo;
         res_lo = '1;
      end else if (op_q) begin
         res_lo = (a_neg ^ b_neg) ? -lo_nx : lo_nx;
         res_hi = a_neg ? -hi_nx[WIDTH-1:0] : hi_nx[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt         <= '0;
         op_q        <= 1'b0;
         dz_q        <= 1'b0;
         a_neg       <= 1'b0;
         b_neg       <= 1'b0;
         qm1         <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         m           <= '0;
         div_by_zero <= 1'b0;
         Z_high      <= '0;
         Z_low       <= '0;
      end else if (capture) begin
         op_q        <= op;
         div_by_zero <= 1'b0;
         qm1         <= 1'b0;
         hi          <= '0;
         cnt         <= CW'(WIDTH);
         dz_q        <= op && (B == '0);
         a_neg       <= op & A[WIDTH-1];
         b_neg       <= op & B[WIDTH-1];
         if (op) begin
            m  <= B[WIDTH-1] ? -B : B;
            lo <= A[WIDTH-1] ? -A : A;
            // divide by zero keeps the raw dividend and finishes on the next edge
            if (B == '0) begin
               lo  <= A;
               cnt <= CW'(1);
            end
         end else begin
            m  <= A;
            lo <= B;
         end
      end else if (state == RUN) begin
         cnt <= cnt - CW'(1);
         if (!dz_q) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            qm1 <= lo[0];
         end
         if (last) begin
            Z_high      <= res_hi;
            Z_low       <= res_lo;
            div_by_zero <= dz_q;
         end
      end
   end

endmodule

// File: tb/tb_seq_mul_div.sv
// Bench for seq_mul_div: directed and random operations checked against
// plain 64-bit signed arithmetic.
module tb_seq_mul_div;

   logic        clk, clr, start, op;
   logic [31:0] A, B;
   logic        busy, done, div_by_zero;
   logic [31:0] Z_high, Z_low;

   int total = 0;
   int bad   = 0;

   seq_mul_div #(.WIDTH(32)) dut (
      .clk(clk), .clr(clr), .start(start), .op(op), .A(A), .B(B),
      .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .Z_high(Z_high), .Z_low(Z_low)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b);
      longint x, y, p;
      x = longint'($signed(a));
      y = longint'($signed(b));
      p = x * y;
      return p;
   endfunction

   // returns {remainder, quotient}
   function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b);
      longint x, y, q, r;
      logic [31:0] q32, r32;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      x = longint'($signed(a));
      y = longint'($signed(b));
      q = x / y;
      r = x % y;
      q32 = q[31:0];
      r32 = r[31:0];
      return {r32, q32};
   endfunction

   task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_n,
                         output logic [31:0] zh, output logic [31:0] zl, output logic dz);
      @(negedge clk);
      op = o; A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; A = $urandom; B = $urandom; op = 1'($urandom);
      lat = -1;
      busy_n = busy ? 1 : 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (done) begin lat = i; break; end
         if (busy) busy_n++;
      end
      zh = Z_high; zl = Z_low; dz = div_by_zero;
   endtask

   task automatic test_reset;
      clr = 1'b0; start = 1'b0; op = 1'b0; A = '0; B = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({busy, done, div_by_zero, Z_high, Z_low} !== 99'd0) begin
         bad++;
         $display("FAIL reset: got busy=%b done=%b dz=%b zh=%h zl=%h want all zero",
                  busy, done, div_by_zero, Z_high, Z_low);
      end
      @(negedge clk); clr = 1'b1;
   endtask

   task automatic test_mul_directed;
      logic [31:0] va[3] = '{32'd7, 32'h7FFF_FFFF, 32'h8000_0000};
      logic [31:0] vb[3] = '{32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000};
      logic [63:0] want[3] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h3FFF_FFFF_0000_0001, 64'h4000_0000_0000_0000};
      int lat, bn; logic [31:0] zh, zl; logic dz;
      for (int i = 0; i < 3; i++) begin
         run_op(1'b0, va[i], vb[i], lat, bn, zh, zl, dz);
         total++;
         if (lat != 32 || bn != 32) begin
            bad++;
            $display("FAIL mul_latency[%0d]: got lat=%0d busy=%0d want 32/32", i, lat, bn);
         end
         total++;
         if ({zh, zl} !== want[i] || {zh, zl} !== model_mul(va[i], vb[i]) || dz !== 1'b0) begin
            bad++;
            $display("FAIL mul_dir[%0d]: got %h_%h dz=%b want %h dz=0", i, zh, zl, dz, want[i]);
         end
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL done_pulse: got done=%b busy=%b want 0/0", done, busy);
      end
   endtask

   task automatic test_div_directed;
      logic [31:0] va[4] = '{32'hFFFF_FFEF, 32'd100, 32'h0000_1234, 32'h8000_0000};
      logic [31:0] vb[4] = '{32'd5, 32'd7, 32'd0, 32'hFFFF_FFFF};
      logic [63:0] want[4] = '{64'hFFFF_FFFE_FFFF_FFFD, 64'h0000_0002_0000_000E,
                               64'h0000_1234_FFFF_FFFF, 64'h0000_0000_8000_0000};
      logic        wdz[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      int wlat[4] = '{32, 32, 1, 32};
      int lat, bn; logic [31:0] zh, zl; logic dz;
      for (int i = 0; i < 4; i++) begin
         run_op(1'b1, va[i], vb[i], lat, bn, zh, zl, dz);
         total++;
         if (lat != wlat[i]) begin
            bad++;
            $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, wlat[i]);
         end
         total++;
         if ({zh, zl} !== want[i] || {zh, zl} !== model_div(va[i], vb[i]) || dz !== wdz[i]) begin
            bad++;
            $display("FAIL div_dir[%0d]: got %h_%h dz=%b want %h dz=%b", i, zh, zl, dz, want[i], wdz[i]);
         end
      end
   endtask

   task automatic test_random;
      int lat, bn; logic [31:0] a, b, zh, zl; logic dz, o;
      logic [63:0] w;
      for (int i = 0; i < 40; i++) begin
         o = 1'(i % 2);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 9));
            2: b = -32'($urandom_range(1, 9));
            3: a = 32'h8000_0000;
            default: ;
         endcase
         w = o ? model_div(a, b) : model_mul(a, b);
         run_op(o, a, b, lat, bn, zh, zl, dz);
         total++;
         if ({zh, zl} !== w || dz !== (o && b == 32'd0) ||
             lat != ((o && b == 32'd0) ? 1 : 32)) begin
            bad++;
            $display("FAIL random[%0d] op=%b a=%h b=%h: got %h_%h dz=%b lat=%0d want %h",
                     i, o, a, b, zh, zl, dz, lat, w);
         end
      end
   endtask

   task automatic test_ignore_start;
      int lat; logic [63:0] w;
      w = model_mul(32'h0001_2345, 32'hFFFF_0007);
      @(negedge clk);
      op = 1'b0; A = 32'h0001_2345; B = 32'hFFFF_0007; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         if (i == 10) begin
            op = 1'b1; A = 32'd99; B = 32'd3; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done) begin lat = i; break; end
      end
      start = 1'b0;
      total++;
      if (lat != 32 || {Z_high, Z_low} !== w || div_by_zero !== 1'b0) begin
         bad++;
         $display("FAIL ignore_start: got lat=%0d z=%h_%h want lat=32 z=%h", lat, Z_high, Z_low, w);
      end
   endtask

   task automatic test_back_to_back;
      int lat, npulse; logic [63:0] w1, w2; logic stable;
      w1 = model_div(32'hDEAD_BEEF, 32'd1234);
      w2 = model_mul(32'h0BAD_F00D, 32'hC0FF_EE00);
      @(negedge clk);
      op = 1'b1; A = 32'hDEAD_BEEF; B = 32'd1234; start = 1'b1;
      lat = -1;
      for (int i = 0; i <= 100; i++) begin
         @(posedge clk); #1;
         if (done) begin lat = i; break; end
      end
      total++;
      if (lat != 32 || {Z_high, Z_low} !== w1) begin
         bad++;
         $display("FAIL b2b_first: got lat=%0d z=%h_%h want lat=32 z=%h", lat, Z_high, Z_low, w1);
      end
      op = 1'b0; A = 32'h0BAD_F00D; B = 32'hC0FF_EE00;
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL b2b_no_idle: got busy=%b done=%b want 1/0", busy, done);
      end
      stable = 1'b1; npulse = 0; lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (done) begin npulse++; lat = i; break; end
         if ({Z_high, Z_low} !== w1) stable = 1'b0;
      end
      total++;
      if (!stable) begin
         bad++;
         $display("FAIL b2b_z_stable: got changed=1 want changed=0");
      end
      total++;
      if (lat != 32 || npulse != 1 || {Z_high, Z_low} !== w2) begin
         bad++;
         $display("FAIL b2b_second: got lat=%0d z=%h_%h want lat=32 z=%h", lat, Z_high, Z_low, w2);
      end
   endtask

   task automatic test_reset_mid;
      int lat, bn; logic [31:0] zh, zl; logic dz;
      @(negedge clk);
      op = 1'b1; A = 32'h7654_3210; B = 32'd77; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #3 clr = 1'b0;
      #1;
      total++;
      if ({busy, done, div_by_zero, Z_high, Z_low} !== 99'd0) begin
         bad++;
         $display("FAIL reset_mid: got busy=%b done=%b dz=%b zh=%h zl=%h want all zero",
                  busy, done, div_by_zero, Z_high, Z_low);
      end
      @(negedge clk); clr = 1'b1;
      run_op(1'b0, 32'd3, 32'd4, lat, bn, zh, zl, dz);
      total++;
      if (lat != 32 || zh !== 32'd0 || zl !== 32'd12) begin
         bad++;
         $display("FAIL after_reset_mul: got lat=%0d z=%h_%h want lat=32 z=0_c", lat, zh, zl);
      end
   endtask

   initial begin
      test_reset;
      test_mul_directed;
      test_div_directed;
      test_random;
      test_ignore_start;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
